// File: rtl/demux1x4_buf_if.sv
// Handshake bundle for the 1-to-4 buffered demultiplexer.
// The slave modport is the demux's own view; the master modport is
// the view of whatever drives the input and consumes the outputs.
interface demux1x4_buf_if #(
    parameter int width = 16
);
    logic             in_valid;
    logic [width-1:0] in_data;
    logic [1:0]       sel;
    logic             in_ready;
    logic [3:0]       out_valid;
    logic [width-1:0] out_data0;
    logic [width-1:0] out_data1;
    logic [width-1:0] out_data2;
    logic [width-1:0] out_data3;
    logic [3:0]       out_ready;
    logic [31:0]      xfer_cnt;

    modport slave (
        input  in_valid, in_data, sel, out_ready,
        output in_ready, out_valid, out_data0, out_data1, out_data2, out_data3, xfer_cnt
    );

    modport master (
        output in_valid, in_data, sel, out_ready,
        input  in_ready, out_valid, out_data0, out_data1, out_data2, out_data3, xfer_cnt
    );
endinterface

// File: rtl/demux1x4_buf.sv
// demux1x4_buf: routes each input word to one of four channels picked by
// sel. Every channel holds one word (data register plus full flag).
//
// Handshake semantics: a transfer happens on a rising edge where valid and
// ready are both high. in_ready looks only at the selected channel: it is
// high when that channel is empty or is being drained on the same edge, so a
// full, non-draining destination stalls the input even if other channels are
// free. A channel drained and loaded on the same edge stays full with the
// new word (no bubble).
//
// Optional feature: define DEMUX_XFER_CNT_EN to build four 8-bit wrapping
// per-channel output-transfer counters on xfer_cnt; otherwise xfer_cnt is 0.
module demux1x4_buf #(
    parameter int width = 16
) (
    input  logic              clk,
    input  logic              rst,
    demux1x4_buf_if.slave     bus
);

    logic [3:0]       full_q;
    logic [3:0]       full_d;
    logic [width-1:0] data_q [4];
    logic [width-1:0] data_d [4];
    logic [3:0]       load_en;
    logic [3:0]       drain_en;
    logic             in_ready_w;

    // Handshake decode and next-state for every channel buffer.
    always_comb begin
        in_ready_w = ~full_q[bus.sel] | bus.out_ready[bus.sel];
        drain_en   = full_q & bus.out_ready;
        load_en    = '0;
        full_d     = full_q;
        for (int i = 0; i < 4; i++) begin
            data_d[i]  = data_q[i];
            load_en[i] = bus.in_valid & in_ready_w & (bus.sel == 2'(i));
            // A load wins over a drain so a simultaneous drain+load stays full.
            full_d[i]  = load_en[i] | (full_q[i] & ~drain_en[i]);
            if (load_en[i]) begin
                data_d[i] = bus.in_data;
            end
        end
    end

    // Buffer registers; reset clears words and flags without waiting for clk.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            full_q <= '0;
            for (int i = 0; i < 4; i++) begin
                data_q[i] <= '0;
            end
        end else begin
            full_q <= full_d;
            for (int i = 0; i < 4; i++) begin
                data_q[i] <= data_d[i];
            end
        end
    end

    assign bus.in_ready  = in_ready_w;
    assign bus.out_valid = full_q;
    assign bus.out_data0 = data_q[0];
    assign bus.out_data1 = data_q[1];
    assign bus.out_data2 = data_q[2];
    assign bus.out_data3 = data_q[3];

`ifdef DEMUX_XFER_CNT_EN
    logic [7:0] cnt_q [4];
    logic [7:0] cnt_d [4];

    // Count output handshakes per channel, wrapping 255 -> 0.
    always_comb begin
        for (int i = 0; i < 4; i++) begin
            cnt_d[i] = cnt_q[i];
            if (drain_en[i]) begin
                cnt_d[i] = cnt_q[i] + 8'd1;
            end
        end
    end

    // Counter registers, cleared asynchronously with the buffers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 4; i++) begin
                cnt_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < 4; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
        end
    end

    assign bus.xfer_cnt = {cnt_q[3], cnt_q[2], cnt_q[1], cnt_q[0]};
`else
    assign bus.xfer_cnt = '0;
`endif

endmodule
